// File: rtl/perfect_scanner.sv
// perfect_scanner: walks candidates lo..hi and drives a perfect-number checker
// through its go/over handshake, reporting each perfect hit.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   start, lo, hi     scan request and inclusive candidate range
//   chk_sw, chk_go    candidate and run request to the checker
//   chk_ans, chk_over checker result and completion flag
//   found_valid/num   one-cycle strobe with the perfect candidate
//   count             saturating hit count for the current/last scan
//   busy, done        scan in progress / scan finished
//   timeout_err       sticky: a candidate was abandoned this scan
module perfect_scanner #(
  parameter int unsigned W       = 16,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     lo,
  input  logic [W-1:0]     hi,
  output logic [W-1:0]     chk_sw,
  output logic             chk_go,
  input  logic             chk_ans,
  input  logic             chk_over,
  output logic             found_valid,
  output logic [W-1:0]     found_num,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RELEASE, FIN} state_t;

  state_t           state, state_n;
  logic [W-1:0]     cur, cur_n, last, last_n;
  logic [TW-1:0]    tmo, tmo_n;
  logic [W-1:0]     chk_sw_n, found_num_n;
  logic             chk_go_n, found_valid_n, busy_n, done_n, timeout_err_n;
  logic [CNT_W-1:0] count_n;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cur         <= '0;
      last        <= '0;
      tmo         <= '0;
      chk_sw      <= '0;
      chk_go      <= 1'b0;
      found_valid <= 1'b0;
      found_num   <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      last        <= last_n;
      tmo         <= tmo_n;
      chk_sw      <= chk_sw_n;
      chk_go      <= chk_go_n;
      found_valid <= found_valid_n;
      found_num   <= found_num_n;
      count       <= count_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout_err <= timeout_err_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    cur_n         = cur;
    last_n        = last;
    tmo_n         = tmo;
    chk_sw_n      = chk_sw;
    chk_go_n      = chk_go;
    found_valid_n = 1'b0;
    found_num_n   = found_num;
    count_n       = count;
    busy_n        = busy;
    done_n        = done;
    timeout_err_n = timeout_err;

    case (state)
      IDLE: begin
        if (start) begin
          cur_n         = lo;
          last_n        = hi;
          count_n       = '0;
          done_n        = 1'b0;
          timeout_err_n = 1'b0;
          if (lo > hi) begin
            state_n = FIN;
          end else begin
            state_n = ISSUE;
            busy_n  = 1'b1;
          end
        end
      end

      ISSUE: begin
        // 0 and 1 are never perfect; step past them without a check
        if (cur < W'(2)) begin
          if (cur == last) begin
            state_n = FIN;
            busy_n  = 1'b0;
          end else begin
            cur_n = cur + W'(1);
          end
        end else begin
          chk_sw_n = cur;
          chk_go_n = 1'b1;
          tmo_n    = '0;
          state_n  = WAIT;
        end
      end

      WAIT: begin
        if (chk_over) begin
          if (chk_ans) begin
            found_valid_n = 1'b1;
            found_num_n   = cur;
            if (count != {CNT_W{1'b1}}) count_n = count + CNT_W'(1);
          end
          chk_go_n = 1'b0;
          state_n  = RELEASE;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          timeout_err_n = 1'b1;
          chk_go_n      = 1'b0;
          state_n       = RELEASE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end

      RELEASE: begin
        // Hold go low until the checker has dropped over (re-armed)
        if (!chk_over) begin
          if (cur == last) begin
            state_n = FIN;
            busy_n  = 1'b0;
          end else begin
            cur_n   = cur + W'(1);
            state_n = ISSUE;
          end
        end
      end

      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_perfect_scanner.sv
// Bench for perfect_scanner: behavioral checker (latency ~5) plus a
// scoreboard of expected perfect hits pushed when each scan is started.
module tb_perfect_scanner;
  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [W-1:0]     lo = '0;
  logic [W-1:0]     hi = '0;
  logic [W-1:0]     chk_sw;
  logic             chk_go;
  logic             chk_ans;
  logic             chk_over;
  logic             found_valid;
  logic [W-1:0]     found_num;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             timeout_err;

  always #5 clk = ~clk;

  perfect_scanner #(.W(W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi),
    .chk_sw(chk_sw), .chk_go(chk_go), .chk_ans(chk_ans), .chk_over(chk_over),
    .found_valid(found_valid), .found_num(found_num), .count(count),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int go_pulses = 0;
  int go_hi6    = 0;
  int sw_low    = 0;
  int both_hi   = 0;
  int hang      = -1;
  logic prev_go = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_perfect(input int n);
    int s;
    if (n < 2) return 1'b0;
    s = 1;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) begin
        s += d;
        if (d != n / d) s += n / d;
      end
    end
    return s == n;
  endfunction

  // Behavioral checker: answers ~5 cycles after go, holds over while go is
  // high, drops over the cycle after go falls. Never answers for 'hang'.
  logic m_over = 1'b0;
  logic m_ans  = 1'b0;
  int   m_cnt  = 0;
  assign chk_over = m_over;
  assign chk_ans  = m_ans;

  always @(posedge clk) begin
    if (!chk_go) begin
      m_over <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_over) begin
      if (m_cnt == 4 && int'(chk_sw) != hang) begin
        m_over <= 1'b1;
        m_ans  <= is_perfect(int'(chk_sw));
      end else if (m_cnt < 4) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Monitor: scoreboard pops on found_valid, plus handshake bookkeeping
  always @(negedge clk) begin
    if (rst) begin
      if (chk_go && !prev_go) go_pulses++;
      if (chk_go && chk_sw < W'(2)) sw_low++;
      if (chk_go && chk_sw == W'(6)) go_hi6++;
      if (done && busy) both_hi++;
      if (found_valid) begin
        if (exp_q.size() == 0) chk("found_extra", found_num, -1);
        else chk("found_num", found_num, exp_q.pop_front());
      end
    end
    prev_go = chk_go;
  end

  task automatic start_scan(input int l, input int h);
    @(negedge clk);
    go_pulses = 0;
    go_hi6    = 0;
    sw_low    = 0;
    both_hi   = 0;
    for (int c = l; c <= h; c++)
      if (c >= 2 && c != hang && is_perfect(c)) exp_q.push_back(c);
    lo    = W'(l);
    hi    = W'(h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk("done", done, 1);
  endtask

  task automatic end_checks(input int ecount, input int eterr, input int ego);
    chk("count", count, ecount);
    chk("busy", busy, 0);
    chk("timeout_err", timeout_err, eterr);
    chk("go_pulses", go_pulses, ego);
    chk("missing_found", exp_q.size(), 0);
    chk("sw_below_2", sw_low, 0);
    chk("done_and_busy", both_hi, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_go"}, chk_go, 0);
    chk({tag, "_sw"}, chk_sw, 0);
    chk({tag, "_fv"}, found_valid, 0);
    chk({tag, "_fn"}, found_num, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_terr"}, timeout_err, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;

    // Basic scan: perfect 6 and 28, candidates 2..30 issued
    start_scan(1, 30);
    wait_done(2000);
    end_checks(2, 0, 29);

    // Empty range: done within two edges, no checks
    start_scan(30, 27);
    @(negedge clk);
    chk("empty_done", done, 1);
    end_checks(0, 0, 0);

    // Top of range terminates without wrapping
    start_scan(65530, 65535);
    wait_done(500);
    end_checks(0, 0, 6);

    // Checker hangs on 6: abandoned after TIMEOUT wait cycles, 7 still issued
    hang = 6;
    start_scan(6, 7);
    wait_done(500);
    end_checks(0, 1, 2);
    chk("go_high_on_6", go_hi6, TMO);
    hang = -1;

    // Reset in the middle of a wait aborts the scan
    start_scan(1, 500);
    for (int i = 0; i < 5000; i++) begin
      if (chk_go && chk_sw == W'(100)) break;
      @(negedge clk);
    end
    chk("reach_100", chk_sw, 100);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    start_scan(490, 500);
    wait_done(2000);
    end_checks(1, 0, 11);

    // start while busy is ignored
    start_scan(20, 30);
    repeat (20) @(negedge clk);
    lo    = W'(1);
    hi    = W'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    end_checks(1, 0, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
